// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
// Bundles the control, ROM and IF/ID signals of the instruction-fetch
// controller so that they travel as one port.
//
// Signals:
//   stall          hazard unit asks fetch to hold PC and IF/ID contents
//   redirect_valid EX resolved a taken branch/jal/jalr this cycle
//   redirect_pc    byte target of the redirect
//   rom_addr       word address to the combinational instruction ROM
//   rom_instr      ROM data for rom_addr, valid in the same cycle
//   pc             current fetch PC (byte address)
//   if_pc          IF/ID registered PC of the held instruction
//   if_instr       IF/ID registered instruction
//   if_valid       IF/ID holds a real fetched instruction
//   halted         fetch FSM is in HALT
//   fetch_count    saturating count of instructions delivered with if_valid=1
//
// Handshake semantics: there is no ready/backpressure on this bus.
// redirect_valid is a single-cycle qualifier for redirect_pc and is consumed
// on the rising edge where it is high. stall is a level that holds fetch for
// every edge on which it is high. A redirect always wins over a stall.
//
// Modports:
//   master  the fetch sequencer (drives ROM address and IF/ID outputs)
//   slave   the surrounding pipeline, hazard unit and ROM
// -----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_instr;
    logic [31:0]       pc;
    logic [31:0]       if_pc;
    logic [31:0]       if_instr;
    logic              if_valid;
    logic              halted;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  rom_instr,
        output rom_addr,
        output pc,
        output if_pc,
        output if_instr,
        output if_valid,
        output halted,
        output fetch_count
    );

    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output rom_instr,
        input  rom_addr,
        input  pc,
        input  if_pc,
        input  if_instr,
        input  if_valid,
        input  halted,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
// Instruction-fetch controller. Owns the program counter, addresses the
// combinational instruction ROM and registers each fetched word into the
// IF/ID stage. Handles hazard stalls, EX redirects (squashing the wrong-path
// instruction with a NOP bubble) and speculative halt detection.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    fetch_sequencer_if.master (see interface file for signal list)
//
// The FSM state is directly observable on bus.halted (HALT <=> halted=1).
// -----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int          ADDR_W     = 5,
    parameter logic [31:0] HALT_INSTR = 32'hffff_ffff,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int          CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_sequencer_if.master    bus
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_pc_q, if_pc_d;
    logic [31:0]      if_instr_q, if_instr_d;
    logic             if_valid_q, if_valid_d;
    logic [CNT_W-1:0] fetch_count_q, fetch_count_d;

    logic             is_halt_word;

    assign is_halt_word = (bus.rom_instr == HALT_INSTR);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= 32'h0;
            if_pc_q       <= 32'h0;
            if_instr_q    <= NOP_INSTR;
            if_valid_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_pc_q       <= if_pc_d;
            if_instr_q    <= if_instr_d;
            if_valid_q    <= if_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    // Next-state logic. Priority: redirect > stall > normal fetch.
    // A redirect also cancels a halt that was fetched down a wrong path.
    always_comb begin
        state_d = state_q;
        if (bus.redirect_valid) begin
            state_d = ST_RUN;
        end else if (!bus.stall && state_q == ST_RUN && is_halt_word) begin
            state_d = ST_HALT;
        end
    end

    // Datapath next values, with the same priority as the FSM.
    always_comb begin
        pc_d          = pc_q;
        if_pc_d       = if_pc_q;
        if_instr_d    = if_instr_q;
        if_valid_d    = if_valid_q;
        fetch_count_d = fetch_count_q;

        if (bus.redirect_valid) begin
            // Byte-offset bits of the target are dropped; squash IF/ID.
            pc_d       = {bus.redirect_pc[31:2], 2'b00};
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end else if (bus.stall) begin
            // everything holds
        end else if (state_q == ST_RUN) begin
            if_instr_d = bus.rom_instr;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            if (fetch_count_q != CNT_MAX) begin
                fetch_count_d = fetch_count_q + 1'b1;
            end
            // The halt word is delivered, but the PC stays on it.
            if (!is_halt_word) begin
                pc_d = pc_q + 32'd4;
            end
        end else begin
            if_instr_d = NOP_INSTR;
            if_valid_d = 1'b0;
        end
    end

    // Outputs. rom_addr comes straight from the PC register, so there is
    // no combinational path from stall/redirect to the ROM address.
    always_comb begin
        bus.rom_addr    = pc_q[ADDR_W+1:2];
        bus.pc          = pc_q;
        bus.if_pc       = if_pc_q;
        bus.if_instr    = if_instr_q;
        bus.if_valid    = if_valid_q;
        bus.halted      = (state_q == ST_HALT);
        bus.fetch_count = fetch_count_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] HALT = 32'hffff_ffff;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk;
  logic rst_n;

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ROM image, combinational read
  logic [31:0] rom [32];
  assign bus.rom_instr = rom[bus.rom_addr];

  // reference model state
  logic [31:0] m_pc, m_if_pc, m_if_instr;
  logic        m_if_valid, m_halted;
  int          m_count;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_pc = 0; m_if_pc = 0; m_if_instr = NOP; m_if_valid = 0; m_halted = 0; m_count = 0;
  endtask

  task automatic model_step(input logic s, input logic rv, input logic [31:0] rp);
    logic [31:0] word;
    word = rom[(m_pc / 4) % 32];
    if (rv) begin
      m_pc = rp & ~32'd3;
      m_if_instr = NOP;
      m_if_valid = 0;
      m_halted = 0;
    end else if (s) begin
      // hold
    end else if (!m_halted) begin
      m_if_instr = word;
      m_if_pc = m_pc;
      m_if_valid = 1;
      if (m_count < 65535) m_count = m_count + 1;
      if (word == HALT) m_halted = 1;
      else m_pc = m_pc + 4;
    end else begin
      m_if_instr = NOP;
      m_if_valid = 0;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input logic s, input logic rv, input logic [31:0] rp);
    bus.stall = s;
    bus.redirect_valid = rv;
    bus.redirect_pc = rp;
    model_step(s, rv, rp);
    @(posedge clk);
    #1;
    bus.stall = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
  endtask

  task automatic do_reset();
    bus.stall = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic fill_rom_seq();
    for (int i = 0; i < 32; i++) rom[i] = 32'h1000_0001 + 32'(i) * 32'h0001_0100;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fill_rom_seq();
    bus.stall = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    rst_n = 0;
    model_reset();
    #3;
    n_checks++;
    if ({bus.pc, bus.if_pc, bus.if_instr, bus.if_valid, bus.halted, bus.fetch_count, bus.rom_addr}
        !== {32'h0, 32'h0, NOP, 1'b0, 1'b0, 16'h0, 5'h0})
      $display("FAIL reset: pc=%h if_pc=%h if_instr=%h v=%b h=%b cnt=%0d addr=%0d, want 0/0/%h/0/0/0/0",
               bus.pc, bus.if_pc, bus.if_instr, bus.if_valid, bus.halted, bus.fetch_count, bus.rom_addr, NOP);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_sequential();
    fill_rom_seq();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0);
      n_checks++;
      if ({bus.if_pc, bus.if_instr, bus.if_valid, bus.fetch_count, bus.pc}
          !== {32'(4 * i), rom[i], 1'b1, 16'(i + 1), 32'(4 * i + 4)})
        $display("FAIL seq[%0d]: if_pc=%h if_instr=%h v=%b cnt=%0d pc=%h, want %h/%h/1/%0d/%h",
                 i, bus.if_pc, bus.if_instr, bus.if_valid, bus.fetch_count, bus.pc,
                 4 * i, rom[i], i + 1, 4 * i + 4);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    fill_rom_seq();
    do_reset();
    repeat (3) tick(0, 0, 0);  // if_pc=8, pc=12, count=3
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 0);
      n_checks++;
      if ({bus.if_pc, bus.if_instr, bus.pc, bus.fetch_count, bus.if_valid}
          !== {32'd8, rom[2], 32'd12, 16'd3, 1'b1})
        $display("FAIL stall[%0d]: if_pc=%h if_instr=%h pc=%h cnt=%0d v=%b, want 8/%h/c/3/1",
                 i, bus.if_pc, bus.if_instr, bus.pc, bus.fetch_count, bus.if_valid, rom[2]);
      else n_pass++;
    end
    tick(0, 0, 0);
    n_checks++;
    if ({bus.if_pc, bus.if_instr, bus.fetch_count} !== {32'd12, rom[3], 16'd4})
      $display("FAIL stall_resume: if_pc=%h if_instr=%h cnt=%0d, want c/%h/4",
               bus.if_pc, bus.if_instr, bus.fetch_count, rom[3]);
    else n_pass++;
  endtask

  task automatic test_redirect();
    fill_rom_seq();
    do_reset();
    repeat (2) tick(0, 0, 0);  // pc=8
    tick(0, 1, 32'h10);
    n_checks++;
    if ({bus.if_valid, bus.if_instr, bus.pc} !== {1'b0, NOP, 32'd16})
      $display("FAIL redirect_squash: v=%b if_instr=%h pc=%h, want 0/%h/10",
               bus.if_valid, bus.if_instr, bus.pc, NOP);
    else n_pass++;
    tick(0, 0, 0);
    n_checks++;
    if ({bus.if_pc, bus.if_valid, bus.if_instr} !== {32'd16, 1'b1, rom[4]})
      $display("FAIL redirect_target: if_pc=%h v=%b if_instr=%h, want 10/1/%h",
               bus.if_pc, bus.if_valid, bus.if_instr, rom[4]);
    else n_pass++;
  endtask

  task automatic test_redirect_vs_stall();
    fill_rom_seq();
    do_reset();
    repeat (2) tick(0, 0, 0);
    tick(1, 1, 32'h0000_0032);
    n_checks++;
    if ({bus.pc, bus.if_valid, bus.if_instr} !== {32'h30, 1'b0, NOP})
      $display("FAIL redirect_vs_stall: pc=%h v=%b if_instr=%h, want 30/0/%h",
               bus.pc, bus.if_valid, bus.if_instr, NOP);
    else n_pass++;
    tick(0, 0, 0);
    n_checks++;
    if ({bus.if_pc, bus.if_valid, bus.if_instr} !== {32'h30, 1'b1, rom[12]})
      $display("FAIL redirect_vs_stall_target: if_pc=%h v=%b if_instr=%h, want 30/1/%h",
               bus.if_pc, bus.if_valid, bus.if_instr, rom[12]);
    else n_pass++;
  endtask

  task automatic test_halt_cancel();
    fill_rom_seq();
    rom[3] = HALT;
    do_reset();
    repeat (4) tick(0, 0, 0);
    n_checks++;
    if ({bus.if_instr, bus.if_valid, bus.pc, bus.halted, bus.if_pc} !== {HALT, 1'b1, 32'd12, 1'b1, 32'd12})
      $display("FAIL halt_fetch: if_instr=%h v=%b pc=%h halted=%b if_pc=%h, want ffffffff/1/c/1/c",
               bus.if_instr, bus.if_valid, bus.pc, bus.halted, bus.if_pc);
    else n_pass++;
    repeat (2) begin
      tick(0, 0, 0);
      n_checks++;
      if ({bus.if_instr, bus.if_valid, bus.pc, bus.halted, bus.fetch_count} !== {NOP, 1'b0, 32'd12, 1'b1, 16'd4})
        $display("FAIL halt_bubble: if_instr=%h v=%b pc=%h halted=%b cnt=%0d, want %h/0/c/1/4",
                 bus.if_instr, bus.if_valid, bus.pc, bus.halted, bus.fetch_count, NOP);
      else n_pass++;
    end
    tick(0, 1, 32'h10);
    n_checks++;
    if ({bus.halted, bus.pc, bus.if_valid} !== {1'b0, 32'd16, 1'b0})
      $display("FAIL halt_redirect: halted=%b pc=%h v=%b, want 0/10/0", bus.halted, bus.pc, bus.if_valid);
    else n_pass++;
    tick(0, 0, 0);
    n_checks++;
    if ({bus.if_pc, bus.if_valid, bus.if_instr, bus.pc} !== {32'd16, 1'b1, rom[4], 32'd20})
      $display("FAIL halt_resume: if_pc=%h v=%b if_instr=%h pc=%h, want 10/1/%h/14",
               bus.if_pc, bus.if_valid, bus.if_instr, bus.pc, rom[4]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    fill_rom_seq();
    rom[6] = HALT;
    do_reset();
    repeat (7) tick(0, 0, 0);
    tick(0, 0, 0);  // one bubble in HALT
    n_checks++;
    if ({bus.halted, bus.fetch_count} !== {1'b1, 16'd7})
      $display("FAIL async_setup: halted=%b cnt=%0d, want 1/7", bus.halted, bus.fetch_count);
    else n_pass++;
    #3;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if ({bus.pc, bus.if_valid, bus.halted, bus.fetch_count, bus.if_instr} !== {32'h0, 1'b0, 1'b0, 16'h0, NOP})
      $display("FAIL async_reset: pc=%h v=%b halted=%b cnt=%0d if_instr=%h, want 0/0/0/0/%h",
               bus.pc, bus.if_valid, bus.halted, bus.fetch_count, bus.if_instr, NOP);
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    logic s, rv;
    logic [31:0] rp;
    for (int i = 0; i < 32; i++) rom[i] = ($urandom_range(0, 9) == 0) ? HALT : $urandom;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      s  = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 7) == 0);
      rp = $urandom;
      tick(s, rv, rp);
      n_checks++;
      if ({bus.pc, bus.if_pc, bus.if_instr, bus.if_valid, bus.halted, bus.fetch_count, bus.rom_addr}
          !== {m_pc, m_if_pc, m_if_instr, m_if_valid, m_halted, 16'(m_count), m_pc[6:2]})
        $display("FAIL random[%0d]: pc=%h if_pc=%h if_instr=%h v=%b h=%b cnt=%0d, want %h/%h/%h/%b/%b/%0d",
                 i, bus.pc, bus.if_pc, bus.if_instr, bus.if_valid, bus.halted, bus.fetch_count,
                 m_pc, m_if_pc, m_if_instr, m_if_valid, m_halted, m_count);
      else n_pass++;
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst_n = 0;
    bus.stall = 0;
    bus.redirect_valid = 0;
    bus.redirect_pc = 0;
    fill_rom_seq();
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_vs_stall();
    test_halt_cancel();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction-fetch controller for the pipelined CPU. Owns the program counter and drives the address of the combinational instruction ROM (5-bit word address, 32-bit instruction). Registers each fetched instruction into the IF/ID stage and handles these events:
- stalls from the hazard unit
- branch/jump redirects from EX
- speculative halt detection (32'hffff_ffff)

Parameters:
ADDR_W, 5, ROM word-address width; ROM spans 2^(ADDR_W+2) bytes.
HALT_INSTR, 32'hffff_ffff, encoding that stops fetch.
NOP_INSTR, 32'h0000_0013, bubble injected on squash/halt (addi x0,x0,0).
CNT_W, 16, width of fetch performance counter.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hazard unit: hold PC and IF/ID contents.
redirect_valid  in  1  EX resolved taken branch/jal/jalr this cycle.
redirect_pc  in  32  byte target of redirect.
rom_addr  out  ADDR_W  word address to ROM, = pc[ADDR_W+1:2], combinational.
rom_instr  in  32  ROM data, valid same cycle as rom_addr.
pc  out  32  current fetch PC (byte address).
if_pc  out  32  IF/ID registered PC of held instruction.
if_instr  out  32  IF/ID registered instruction.
if_valid  out  1  IF/ID holds a real fetched instruction.
halted  out  1  fetch is in HALT state.
fetch_count  out  CNT_W  number of instructions delivered with if_valid=1, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - pc=0, if_pc=0, if_instr=NOP_INSTR, if_valid=0, halted=0, fetch_count=0, state=RUN.
  - Release is sampled on the next rising edge. First fetch address is 0; first valid IF/ID output appears one cycle after release.
- State machine has two states: RUN and HALT. halted = (state==HALT), registered.
- Per-edge priority: redirect_valid > stall > normal fetch. Applies in both states.
- Redirect (redirect_valid=1, regardless of stall or state):
  - pc <= {redirect_pc[31:2],2'b00}; low bits are silently dropped.
  - if_instr <= NOP_INSTR, if_valid <= 0 (squash wrong-path instruction).
  - state <= RUN. A halt fetched down a wrong path is cancelled.
- Stall (stall=1, no redirect): pc, if_pc, if_instr, if_valid, state and fetch_count all hold.
- RUN, no stall/redirect:
  - if_instr <= rom_instr, if_pc <= pc, if_valid <= 1, fetch_count increments.
  - If rom_instr != HALT_INSTR: pc <= pc+4.
  - If rom_instr == HALT_INSTR: pc holds; state <= HALT. The halt word itself is delivered downstream with if_valid=1 so the pipeline can drain and retire it.
- HALT, no stall/redirect:
  - pc holds, if_instr <= NOP_INSTR, if_valid <= 0, fetch_count holds.
  - Exit is only via redirect or reset.
- Latency: redirect to first target instruction valid in IF/ID is 1 edge after the redirect edge, i.e. exactly one squashed bubble.
- PC arithmetic:
  - Full 32-bit, wraps modulo 2^32.
  - rom_addr takes bits [ADDR_W+1:2] only, so PCs beyond the ROM span alias into it. No fault is raised.
- fetch_count saturates at 2^CNT_W-1 and never wraps.
- Reset mid-operation (including mid-stall or in HALT) immediately forces all reset values.
- No combinational path from stall/redirect to rom_addr; rom_addr depends only on the pc register.

Test Plan:
- Sequential fetch: ROM words 0..3 distinct non-halt, no stall -> if_pc sequence 0,4,8,12 on consecutive edges after reset release. if_instr matches ROM. fetch_count=4.
- Stall hold: assert stall for 3 cycles while if_pc=8 -> if_pc=8, if_instr, pc=12 and fetch_count frozen for 3 cycles. Resumes with if_pc=12.
- Redirect squash:
  - Setup: redirect_valid=1, redirect_pc=32'h10 while pc=8.
  - Next edge: if_valid=0, if_instr=32'h0000_0013, pc=16.
  - Following edge: if_pc=16, if_valid=1.
- Redirect vs stall: redirect_valid=1 with stall=1, redirect_pc=32'h0000_0032 -> redirect wins. pc=32'h30 (low bits dropped). One bubble.
- Speculative halt cancelled:
  - Setup: ROM word 3=32'hffff_ffff, fetched after word 2.
  - Expect if_instr=ffff_ffff with if_valid=1 and pc held at 12. halted=1 and bubbles follow.
  - Then redirect_pc=32'h10 -> halted=0, fetch resumes at 16.
- Async reset: drop rst_n mid-cycle while halted with fetch_count=7 -> pc, if_valid, halted and fetch_count are 0 without waiting for a clock edge. if_instr=NOP_INSTR.
